// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared definitions.
// Op codes, FSM states and small op-class helpers.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } mdu_state_t;

  function automatic logic is_md_op(
    input logic [2:0] op
  );
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(
    input logic [2:0] op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(
    input logic [2:0] op
  );
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division step.
// Shifts {rem, quot} left, subtracts divisor when it fits.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WORD_WIDTH = MDU_WIDTH
) (
  input  logic [2*WORD_WIDTH-1:0] rem_quot,
  input  logic [WORD_WIDTH-1:0]   divisor,
  output logic [2*WORD_WIDTH-1:0] next_rem_quot
);

  localparam int W = WORD_WIDTH;

  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         fits;
  logic [W-1:0] rem_next;

  assign shifted = {rem_quot[2*W-1:W], rem_quot[W-1]};
  assign diff    = shifted - {1'b0, divisor};
  // a set top bit of the difference means it went negative
  assign fits     = ~diff[W];
  assign rem_next = fits ? diff[W-1:0] : shifted[W-1:0];

  assign next_rem_quot = {rem_next, rem_quot[W-2:0], fits};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// One bit per cycle; sign handled before and after the loop.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WORD_WIDTH = MDU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            mdu_op,
  input  logic [WORD_WIDTH-1:0] in_a,
  input  logic [WORD_WIDTH-1:0] in_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W + 1);

  mdu_state_t      state;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            sign_r;
  logic            div_zero;

  logic            op_div;
  logic            op_sgn;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W-1:0]    addend;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix;
  logic [W-1:0]    rem_fix;

  assign op_div = is_div_op(op_q);
  assign op_sgn = is_signed_op(op_q);

  assign a_mag = (op_sgn && a_q[W-1]) ? -a_q : a_q;
  assign b_mag = (op_sgn && b_q[W-1]) ? -b_q : b_q;

  assign addend   = acc[0] ? b_q : '0;
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc[W-1:1]};

  mdu_div_step #(
    .WORD_WIDTH (W)
  ) u_div_step (
    .rem_quot      (acc),
    .divisor       (b_q),
    .next_rem_quot (div_next)
  );

  // a zero divisor keeps the all-ones quotient unsigned
  assign prod_fix = sign_q ? -acc : acc;
  assign quot_fix = (sign_q && !div_zero) ? -acc[W-1:0]
                                          : acc[W-1:0];
  assign rem_fix  = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  // control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= MDU_NOP;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              unique case (1'b1)
                is_md_op(mdu_op): begin
                  op_q  <= mdu_op;
                  a_q   <= in_a;
                  b_q   <= in_b;
                  busy  <= 1'b1;
                  state <= ST_PREP;
                end
                (mdu_op == MDU_MTHI): hi <= in_a;
                (mdu_op == MDU_MTLO): lo <= in_a;
                default: ;
              endcase
            end
          end
          ST_PREP: begin
            b_q      <= b_mag;
            acc      <= {{W{1'b0}}, a_mag};
            sign_q   <= op_sgn & (a_q[W-1] ^ b_q[W-1]);
            sign_r   <= op_sgn & a_q[W-1];
            div_zero <= (b_q == '0);
            cnt      <= CW'(W);
            state    <= ST_ITER;
          end
          ST_ITER: begin
            acc <= op_div ? div_next : mul_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (op_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit.
// Directed corners plus random ops against an arithmetic model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(
    .WORD_WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdu_op (mdu_op),
    .in_a   (in_a),
    .in_b   (in_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    res = '0;
    case (op)
      MDU_MULT:  res = sa * sb;
      MDU_MULTU: res = {32'b0, a} * {32'b0, b};
      MDU_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MDU_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // issue op now, return edges from accept to done
  task automatic run_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output bit          busy_ok
  );
    start = 1'b1;
    mdu_op = op;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    mdu_op = MDU_NOP;
    in_a = $urandom;
    in_b = $urandom;
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    cancel = 1'b0;
    mdu_op = MDU_NOP;
    in_a = '0;
    in_b = '0;
    #12;
    checks++;
    if (hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo);
    end
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0",
               busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] eh [7];
    logic [31:0] el [7];
    int lat;
    bit bok;
    ops = '{MDU_MULTU, MDU_MULT, MDU_DIV, MDU_DIVU,
            MDU_DIV, MDU_DIV, MDU_DIVU};
    va = '{32'hFFFF_FFFF, -32'sd3, -32'sd7, 32'd100,
           32'h1234, 32'h8000_0000, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7,
           32'h0, 32'hFFFF_FFFF, 32'h8000_0001};
    eh = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
           32'h1234, 32'h0, 32'h7FFF_FFFE};
    el = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14,
           32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], va[i], vb[i], lat, bok);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d want=%0d",
                 i, lat, LAT);
      end
      checks++;
      if (!bok || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy held=%b at_done=%b want 1/0",
                 i, bok, busy);
      end
      checks++;
      if (hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL dir%0d_result hi=%h lo=%h want %h %h",
                 i, hi, lo, eh[i], el[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_done_pulse done=%b want 0",
                 i, done);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1;
    mdu_op = MDU_MTHI;
    in_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi hi=%h busy=%b want deadbeef 0",
               hi, busy);
    end
    mdu_op = MDU_MTLO;
    in_a = 32'h0BAD_F00D;
    @(posedge clk); #1;
    checks++;
    if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mtlo hi=%h lo=%h want deadbeef 0badf00d",
               hi, lo);
    end
    mdu_op = MDU_NOP;
    in_a = 32'h1111_1111;
    @(posedge clk); #1;
    mdu_op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL nop_op hi=%h lo=%h busy=%b want unchanged",
               hi, lo, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1;
    mdu_op = MDU_MULT;
    in_a = 32'd5;
    in_b = -32'sd6;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1;
    mdu_op = MDU_MTLO;
    in_a = 32'h5555_5555;
    @(posedge clk); #1;
    lat++;
    mdu_op = MDU_MTHI;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    mdu_op = MDU_NOP;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL busy_ignore_latency got=%0d want=%0d",
               lat, LAT);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFE2) begin
      errors++;
      $display("FAIL busy_ignore hi=%h lo=%h want ffffffff ffffffe2",
               hi, lo);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] h0, l0;
    int lat;
    bit bok;
    logic [63:0] exp;
    h0 = 32'hCAFE_0001;
    l0 = 32'hCAFE_0002;
    start = 1'b1;
    mdu_op = MDU_MTHI;
    in_a = h0;
    @(posedge clk); #1;
    mdu_op = MDU_MTLO;
    in_a = l0;
    @(posedge clk); #1;
    // abort mid-iteration
    mdu_op = MDU_MULT;
    in_a = 32'd123;
    in_b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0 || hi !== h0 || lo !== l0) begin
      errors++;
      $display("FAIL cancel_iter busy=%b done=%b hi=%h lo=%h",
               busy, done, hi, lo);
    end
    exp = ref_model(MDU_MULT, -32'sd77, 32'd1000);
    run_op(MDU_MULT, -32'sd77, 32'd1000, lat, bok);
    checks++;
    if (lat !== LAT || hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL cancel_restart lat=%0d hi=%h lo=%h want %0d %h",
               lat, hi, lo, LAT, exp);
    end
    h0 = hi;
    l0 = lo;
    // abort in the write-back cycle
    @(posedge clk); #1;
    start = 1'b1;
    mdu_op = MDU_DIVU;
    in_a = 32'd1000;
    in_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_fix_pre busy=%b done=%b want 1 0",
               busy, done);
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0 || hi !== h0 || lo !== l0) begin
      errors++;
      $display("FAIL cancel_fix busy=%b done=%b hi=%h lo=%h",
               busy, done, hi, lo);
    end
    // cancel in idle blocks start
    start = 1'b1;
    cancel = 1'b1;
    mdu_op = MDU_MTHI;
    in_a = 32'h7777_7777;
    @(posedge clk); #1;
    mdu_op = MDU_DIV;
    @(posedge clk); #1;
    start = 1'b0;
    cancel = 1'b0;
    checks++;
    if (hi !== h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle hi=%h busy=%b want %h 0",
               hi, busy, h0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(1, 4));
      a = pick();
      b = pick();
      exp = ref_model(op, a, b);
      run_op(op, a, b, lat, bok);
      checks++;
      if (lat !== LAT || !bok || hi !== exp[63:32] ||
          lo !== exp[31:0]) begin
        errors++;
        $display("FAIL b2b%0d op=%0d a=%h b=%h lat=%0d hi=%h lo=%h want %h",
                 i, op, a, b, lat, hi, lo, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat;
    bit bok;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      a = pick();
      b = pick();
      exp = ref_model(op, a, b);
      run_op(op, a, b, lat, bok);
      checks++;
      if (hi !== exp[63:32] || lo !== exp[31:0]) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h hi=%h lo=%h want %h",
                 i, op, a, b, hi, lo, exp);
      end
      checks++;
      if (lat !== LAT || !bok) begin
        errors++;
        $display("FAIL rand%0d_timing lat=%0d busy_ok=%b want %0d 1",
                 i, lat, bok, LAT);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit bok;
    start = 1'b1;
    mdu_op = MDU_MTHI;
    in_a = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mdu_op = MDU_MTLO;
    @(posedge clk); #1;
    mdu_op = MDU_DIVU;
    in_a = 32'd5000;
    in_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL async_reset hi=%h lo=%h busy=%b done=%b",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(MDU_DIVU, 32'd9, 32'd3, lat, bok);
    checks++;
    if (lat !== LAT || hi !== 0 || lo !== 32'd3) begin
      errors++;
      $display("FAIL post_reset_divu lat=%0d hi=%h lo=%h want 34 0 3",
               lat, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
